spi_master_tx: RTL
==================

// Module: spi_master_tx
// PURPOSE
//  SPI master (mode 0, CPOL=0/CPHA=0, MSB first) generating SCK, SIMO and CS from clk.
//  Drives the SPI slave on the other board end; full-duplex, returns the SOMI byte.
//  Host logic requests a byte with start/tx_data and gets rx_data plus a done pulse.
// PARAMETERS
//  CLK_DIV  4  clk cycles per SCK half-period (legal >= 2; SCK = clk/(2*CLK_DIV))
//  DATA_W   8  bits per transfer
// PORTS
//  clk      in   1       system clock; everything is sampled on its rising edge
//  rst      in   1       reset, asynchronous, active-high
//  start    in   1       request a transfer; accepted only when busy=0
//  tx_data  in   DATA_W  byte to send; captured in the accept cycle
//  rx_data  out  DATA_W  byte received on SOMI; valid from the done cycle until the next done
//  busy     out  1       high from the accept cycle until the end of the CS-high gap
//  done     out  1       one-clk pulse when the last bit has been sampled
//  SCK      out  1       SPI clock, idles low
//  SIMO     out  1       master out / slave in
//  SOMI     in   1       master in / slave out; sampled on SCK rising edge
//  CS       out  1       chip select, active-low
// BEHAVIOUR
//  Reset (async, any state): CS=1, SCK=0, SIMO=0, busy=0, done=0, rx_data=0, state IDLE.
//  Reset during a transfer aborts it with no done pulse.
//  Half-period tick: counter 0..CLK_DIV-1; tick when it reaches CLK_DIV-1. Counter is cleared on each state entry.
//  FSM: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
//  IDLE: start=1 at edge N -> at edge N: CS=0, busy=1, SIMO=tx_data[MSB], shift reg<=tx_data, bit count=0, -> SETUP.
//  SETUP: one half-period with SCK=0, then SCK rises -> SHIFT.
//  SHIFT: at each rising edge, rx shift <= {rx[DATA_W-2:0],SOMI}.
//   Half-period later, SCK falls.
//   If bits remain, SIMO = next bit, MSB first.
//  The DATA_W-th falling edge:
//   - updates rx_data and asserts done for that single cycle;
//   - moves to HOLD.
//  HOLD: one half-period with SCK=0 and CS=0, then CS=1 -> GAP.
//   CS low time = (2*DATA_W+2)*CLK_DIV clk (72 at defaults).
//  GAP: CS=1 for 2*CLK_DIV clk, then busy=0 -> IDLE. Next start is accepted the cycle busy reads 0.
//  start while busy=1 is ignored (no queueing); tx_data changes after the accept cycle have no effect.
//  SIMO holds its last bit during HOLD and changes only on SCK falling edges.
//  SOMI is not synchronised here: with CLK_DIV>=2, data is stable for >=1 clk around sampling.
// CONFIGURATION
//  SPI_MASTER_BURST_EN defined:
//   - start=1 in the done cycle continues the transfer: tx_data is loaded, SIMO=new MSB, CS stays 0, bit count cleared.
//   - The FSM goes straight to SHIFT, so the next rise comes one half-period later (no HOLD/GAP).
//   - busy stays 1.
//  Undefined: start during done is ignored, as it is during any other busy cycle; every byte gets its own CS frame.
// TESTING (CLK_DIV=4, DATA_W=8)
//  1. Loopback SOMI=SIMO, tx 0xA5 -> rx_data=0xA5, done once, CS low 72 clk, 8 SCK rises, busy low 8 clk after CS rises.
//  2. SOMI slave model returns 0x3C while tx 0xFF -> rx_data=0x3C, SIMO high through all 8 bits.
//  3. start pulsed again at mid-transfer and in the done cycle (macro off) -> ignored, no second CS frame.
//  4. rst asserted after 3rd SCK rise -> CS=1, SCK=0, busy=0 same cycle, no done; next start 0x81 completes correctly.
//  5. BURST_EN: tx 0x12 then start with 0x34 in the done cycle -> CS stays low 16 SCK, two done pulses, rx 0x12 then 0x34 in loopback.
//  6. Back-to-back non-burst: start held high -> frames separated by CS high exactly 8 clk, each byte correct.

Source files
------------

// File: rtl/spi_master_tx.sv
// rtl/spi_master_tx.sv - SPI mode-0 master, MSB first, one full-duplex DATA_W-bit transfer per request
// Define SPI_MASTER_BURST_EN to chain a new byte into the same CS frame by asserting start in the done cycle.
module spi_master_tx #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              SCK,
  output logic              SIMO,
  input  logic              SOMI,
  output logic              CS
);

  localparam int CNT_W = $clog2(2 * CLK_DIV);
  localparam int BIT_W = $clog2(DATA_W);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t            state;
  state_t            next_state;
  logic [CNT_W-1:0]  cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic              half_tick;
  logic              load;
  logic              rise;
  logic              fall;
  logic              last;

  // SIMO is the MSB of the transmit shifter, so it only moves when the shifter does.
  assign SIMO      = tx_sh[DATA_W-1];
  assign half_tick = (cnt == CNT_W'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // SHIFT always begins with SCK low, so both SETUP and a burst reload see a full low half-period first.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    rise       = 1'b0;
    fall       = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          next_state = SETUP;
        end
      end
      SETUP: begin
        if (half_tick) begin
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (half_tick) begin
          if (!SCK) begin
            rise = 1'b1;
          end else begin
            fall = 1'b1;
            if (bit_cnt == BIT_W'(DATA_W - 1)) begin
              last       = 1'b1;
              next_state = HOLD;
            end
          end
        end
      end
      HOLD: begin
`ifdef SPI_MASTER_BURST_EN
        if (done && start) begin
          load       = 1'b1;
          next_state = SHIFT;
        end else if (half_tick) begin
          next_state = GAP;
        end
`else
        if (half_tick) begin
          next_state = GAP;
        end
`endif
      end
      GAP: begin
        // The IDLE cycle that follows completes the 2*CLK_DIV CS-high gap.
        if (cnt == CNT_W'(2 * CLK_DIV - 2)) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == IDLE || state != next_state || rise || fall) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      CS      <= 1'b1;
      SCK     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_data <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      bit_cnt <= '0;
    end else begin
      done <= last;
      if (load) begin
        CS      <= 1'b0;
        busy    <= 1'b1;
        tx_sh   <= tx_data;
        bit_cnt <= '0;
      end
      if (rise) begin
        SCK   <= 1'b1;
        rx_sh <= {rx_sh[DATA_W-2:0], SOMI};
      end
      if (fall) begin
        SCK <= 1'b0;
        if (last) begin
          rx_data <= rx_sh;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
          tx_sh   <= {tx_sh[DATA_W-2:0], 1'b0};
        end
      end
      if (state == HOLD && next_state == GAP) begin
        CS <= 1'b1;
      end
      if (state == GAP && next_state == IDLE) begin
        busy <= 1'b0;
      end
    end
  end

endmodule
